priority_encoder_rr_pipe: RTL

//  Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshake.

---
 rtl/priority_encoder_rr_pipe_if.sv | 40 ++++
 rtl/priority_encoder_rr_pipe.sv | 103 ++++++++++
 2 files changed

// File: rtl/priority_encoder_rr_pipe_if.sv
// Handshake bus for priority_encoder_rr_pipe: request side (in_*) and grant side (out_*).
// Optional feature macro: PENC_MASK_EN adds the req_mask request qualifier.
interface priority_encoder_rr_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] req_vec;
  logic             rr_mode;
`ifdef PENC_MASK_EN
  logic [WIDTH-1:0] req_mask;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_onehot;
  logic             out_none;
  logic [CNT_W-1:0] out_count;

  // Environment side: drives requests, consumes grants.
  modport master (
    output in_valid, req_vec, rr_mode, out_ready,
`ifdef PENC_MASK_EN
    output req_mask,
`endif
    input  in_ready, out_valid, out_idx, out_onehot, out_none, out_count
  );

  // Encoder side.
  modport slave (
    input  in_valid, req_vec, rr_mode, out_ready,
`ifdef PENC_MASK_EN
    input  req_mask,
`endif
    output in_ready, out_valid, out_idx, out_onehot, out_none, out_count
  );
endinterface

// File: rtl/priority_encoder_rr_pipe.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshake.
// Fixed (MSB wins) or round-robin grant per accepted vector, plus request popcount.
// Optional feature macro: PENC_MASK_EN (effective vector = req_vec & ~req_mask).
module priority_encoder_rr_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  priority_encoder_rr_pipe_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] eff;
  logic [IDX_W-1:0] fix_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] ptr;
  logic             any;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  int unsigned      rr_pos;

  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] onehot_q;
  logic             none_q;
  logic [CNT_W-1:0] count_q;

  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.in_ready = !valid_q || bus.out_ready;

  // Effective request vector.
  always_comb begin
`ifdef PENC_MASK_EN
    eff = bus.req_vec & ~bus.req_mask;
`else
    eff = bus.req_vec;
`endif
  end

  // Fixed priority: highest set index wins.
  always_comb begin
    fix_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (eff[i]) fix_idx = IDX_W'(i);
    end
  end

  // Round-robin: descend from ptr, wrapping 0 -> WIDTH-1; first set bit wins.
  always_comb begin
    rr_idx = '0;
    rr_pos = 0;
    for (int unsigned k = WIDTH; k > 0; k--) begin
      rr_pos = (32'(ptr) + WIDTH - (k - 1)) % WIDTH;
      if (eff[IDX_W'(rr_pos)]) rr_idx = IDX_W'(rr_pos);
    end
  end

  // Popcount and grant selection.
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(eff[i]);
    end
    any   = |eff;
    grant = bus.rr_mode ? rr_idx : fix_idx;
  end

  // Output registers: load on accept, hold under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      none_q   <= 1'b0;
      count_q  <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      idx_q    <= any ? grant : '0;
      onehot_q <= any ? (WIDTH'(1) << grant) : '0;
      none_q   <= !any;
      count_q  <= cnt;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  // Round-robin pointer: moves just below the last RR grant; untouched otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(WIDTH - 1);
    end else if (accept && bus.rr_mode && any) begin
      ptr <= (grant == '0) ? IDX_W'(WIDTH - 1) : grant - IDX_W'(1);
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_none   = none_q;
  assign bus.out_count  = count_q;
endmodule
